// File: rtl/cc_lane_speed_scheduler.sv
// Speed counter with level-dependent terminal count; each period tick is shared among lane requesters round-robin.
// Optional build macro CC_LANE_SPEED_SCHEDULER_BURST_EN: a tick grants every requesting lane at once.
module cc_lane_speed_scheduler #(
    parameter int DATAWIDTH  = 23,
    parameter int NUM_LANES  = 4,
    parameter int LEVELWIDTH = 3,
    parameter int PERIOD_L2  = 8480,
    parameter int PERIOD_L4  = 4384,
    parameter int PERIOD_L6  = 2336
) (
    input  logic                  cc_lane_speed_scheduler_CLOCK_50,
    input  logic                  cc_lane_speed_scheduler_RESET_InHigh,
    input  logic                  cc_lane_speed_scheduler_Start_InHigh,
    input  logic                  cc_lane_speed_scheduler_Pause_InHigh,
    input  logic                  cc_lane_speed_scheduler_Stop_InHigh,
    input  logic [LEVELWIDTH-1:0] cc_lane_speed_scheduler_Level_InBUS,
    input  logic [NUM_LANES-1:0]  cc_lane_speed_scheduler_Req_InBUS,
    output logic [NUM_LANES-1:0]  cc_lane_speed_scheduler_Grant_OutBUS,
    output logic                  cc_lane_speed_scheduler_Tick_OutLow,
    output logic [1:0]            cc_lane_speed_scheduler_State_OutBUS,
    output logic [LEVELWIDTH-1:0] cc_lane_speed_scheduler_Level_OutBUS
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [DATAWIDTH-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [LEVELWIDTH-1:0] level_q, level_d;
    logic                  tick_n_q, tick_n_d;
    logic [NUM_LANES-1:0]  grant_q, grant_d;

    logic [DATAWIDTH-1:0]  period_sel;
    logic [NUM_LANES-1:0]  arb_grant;
    logic [PTR_W-1:0]      arb_rr;
    logic                  arb_found;
    int                    arb_idx;

    always_comb begin
        case (level_q)
            LEVELWIDTH'(4): period_sel = DATAWIDTH'(PERIOD_L4);
            LEVELWIDTH'(6): period_sel = DATAWIDTH'(PERIOD_L6);
            default:        period_sel = DATAWIDTH'(PERIOD_L2);
        endcase
    end

`ifdef CC_LANE_SPEED_SCHEDULER_BURST_EN
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 0;
        arb_grant = cc_lane_speed_scheduler_Req_InBUS;
        arb_rr    = '0;
    end
`else
    // Search upward from rr_ptr with wrap; first requester wins and the pointer moves past it.
    always_comb begin
        arb_grant = '0;
        arb_rr    = rr_ptr_q;
        arb_found = 1'b0;
        arb_idx   = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NUM_LANES) begin
                arb_idx = arb_idx - NUM_LANES;
            end
            if (!arb_found && cc_lane_speed_scheduler_Req_InBUS[arb_idx]) begin
                arb_found          = 1'b1;
                arb_grant[arb_idx] = 1'b1;
                arb_rr             = (arb_idx == NUM_LANES - 1) ? '0 : PTR_W'(arb_idx + 1);
            end
        end
    end
`endif

    // Pause sampled in RUN freezes the count on that same edge, which also suppresses a coincident match.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        level_d  = level_q;
        tick_n_d = 1'b1;
        grant_d  = '0;
        if (cc_lane_speed_scheduler_Stop_InHigh) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rr_ptr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (cc_lane_speed_scheduler_Start_InHigh) begin
                        state_d = ST_RUN;
                        level_d = cc_lane_speed_scheduler_Level_InBUS;
                    end
                end
                ST_RUN: begin
                    if (cc_lane_speed_scheduler_Pause_InHigh) begin
                        state_d = ST_PAUSE;
                    end else if (cnt_q == period_sel) begin
                        cnt_d    = '0;
                        level_d  = cc_lane_speed_scheduler_Level_InBUS;
                        tick_n_d = 1'b0;
                        grant_d  = arb_grant;
                        rr_ptr_d = arb_rr;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!cc_lane_speed_scheduler_Pause_InHigh) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge cc_lane_speed_scheduler_CLOCK_50 or posedge cc_lane_speed_scheduler_RESET_InHigh) begin
        if (cc_lane_speed_scheduler_RESET_InHigh) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            level_q  <= LEVELWIDTH'(2);
            tick_n_q <= 1'b1;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            level_q  <= level_d;
            tick_n_q <= tick_n_d;
            grant_q  <= grant_d;
        end
    end

    assign cc_lane_speed_scheduler_Grant_OutBUS = grant_q;
    assign cc_lane_speed_scheduler_Tick_OutLow  = tick_n_q;
    assign cc_lane_speed_scheduler_State_OutBUS = state_q;
    assign cc_lane_speed_scheduler_Level_OutBUS = level_q;

endmodule
